// File: rtl/box_coord_sync.sv
//==============================================================================
// Module      : box_coord_sync
// Description : Frame-synchronous commit stage for the VGA box overlay.
//               Accepts face detections over valid/ready, sanitises them into
//               a one-deep pending slot, and on each frame_start commits them
//               to the overlay outputs with temporal smoothing and a coast /
//               timeout policy.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module box_coord_sync #(
  parameter int IMG_WIDTH    = 768,
  parameter int IMG_HEIGHT   = 576,
  parameter int SMOOTH_SHIFT = 2,
  parameter int HOLD_FRAMES  = 8,
  parameter int MIN_SIZE     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        det_valid,
  output logic        det_ready,
  input  logic [10:0] det_x,
  input  logic [10:0] det_y,
  input  logic [10:0] det_w,
  input  logic [10:0] det_h,
  output logic [10:0] box_x,
  output logic [10:0] box_y,
  output logic [10:0] box_w,
  output logic [10:0] box_h,
  output logic        box_en
);

  localparam int                MISS_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [MISS_W-1:0] HOLD_CNT = MISS_W'(HOLD_FRAMES);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
  localparam logic [10:0]       W_MAX    = 11'(IMG_WIDTH - 2);
  localparam logic [10:0]       H_MAX    = 11'(IMG_HEIGHT - 2);
  localparam logic [10:0]       X_LAST   = 11'(IMG_WIDTH - 1);
  localparam logic [10:0]       Y_LAST   = 11'(IMG_HEIGHT - 1);
  localparam logic [10:0]       MIN_SZ   = 11'(MIN_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    COAST = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [MISS_W-1:0] miss, miss_nx, miss_inc;
  logic [10:0]       box_x_nx, box_y_nx, box_w_nx, box_h_nx;
  logic              box_en_nx;

  // Pending slot
  logic        pend_full;
  logic        ready_en;
  logic [10:0] pend_x, pend_y, pend_w, pend_h;

  // Sanitised view of the incoming detection
  logic [10:0] w_even, h_even, w_cl, h_cl, w_half, h_half;
  logic [10:0] x_hi, y_hi, x_cl, y_cl;
  logic        reject, accept;

  // One step of first-order smoothing; a nonzero error always moves by at
  // least one pixel so the box converges exactly onto the target.
  function automatic logic [10:0] smooth(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [11:0] d;
    logic signed [11:0] step;
    d    = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = d >>> SMOOTH_SHIFT;
    if (d != 12'sd0 && step == 12'sd0) begin
      step = d[11] ? -12'sd1 : 12'sd1;
    end
    return cur + step[10:0];
  endfunction

  // ready is held low for the first cycle after reset release, then tracks the slot
  assign det_ready = ready_en & ~pend_full;
  assign accept    = det_valid & det_ready;

  // Round size to even, clamp size to the image, then keep the box fully on screen
  always_comb begin
    w_even = {det_w[10:1], 1'b0};
    h_even = {det_h[10:1], 1'b0};
    w_cl   = (w_even > W_MAX) ? W_MAX : w_even;
    h_cl   = (h_even > H_MAX) ? H_MAX : h_even;
    w_half = {1'b0, w_cl[10:1]};
    h_half = {1'b0, h_cl[10:1]};
    x_hi   = X_LAST - w_half;
    y_hi   = Y_LAST - h_half;
    if (det_x < w_half)     x_cl = w_half;
    else if (det_x > x_hi)  x_cl = x_hi;
    else                    x_cl = det_x;
    if (det_y < h_half)     y_cl = h_half;
    else if (det_y > y_hi)  y_cl = y_hi;
    else                    y_cl = det_y;
    reject = (w_even < MIN_SZ) || (h_even < MIN_SZ);
  end

  // Pending slot: filled by a good transfer, emptied by any frame commit.
  // A transfer is only possible with the slot empty, so fill wins over clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_full <= 1'b0;
      ready_en  <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      pend_w    <= '0;
      pend_h    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept && !reject) begin
        pend_full <= 1'b1;
        pend_x    <= x_cl;
        pend_y    <= y_cl;
        pend_w    <= w_cl;
        pend_h    <= h_cl;
      end else if (frame_start) begin
        pend_full <= 1'b0;
      end
    end
  end

  // Commit state register: FSM, miss counter and the overlay outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      miss   <= '0;
      box_x  <= '0;
      box_y  <= '0;
      box_w  <= '0;
      box_h  <= '0;
      box_en <= 1'b0;
    end else begin
      state  <= state_nx;
      miss   <= miss_nx;
      box_x  <= box_x_nx;
      box_y  <= box_y_nx;
      box_w  <= box_w_nx;
      box_h  <= box_h_nx;
      box_en <= box_en_nx;
    end
  end

  assign miss_inc = miss + MISS_ONE;

  // Frame-boundary commit decisions; outside frame_start everything holds
  always_comb begin
    state_nx  = state;
    miss_nx   = miss;
    box_x_nx  = box_x;
    box_y_nx  = box_y;
    box_w_nx  = box_w;
    box_h_nx  = box_h;
    box_en_nx = box_en;
    if (frame_start) begin
      case (state)
        IDLE: begin
          if (pend_full) begin
            box_x_nx  = pend_x;
            box_y_nx  = pend_y;
            box_w_nx  = pend_w;
            box_h_nx  = pend_h;
            box_en_nx = 1'b1;
            miss_nx   = '0;
            state_nx  = TRACK;
          end
        end
        TRACK, COAST: begin
          if (pend_full) begin
            box_x_nx = smooth(box_x, pend_x);
            box_y_nx = smooth(box_y, pend_y);
            box_w_nx = smooth(box_w, pend_w);
            box_h_nx = smooth(box_h, pend_h);
            miss_nx  = '0;
            state_nx = TRACK;
          end else if (miss_inc == HOLD_CNT) begin
            box_en_nx = 1'b0;
            miss_nx   = '0;
            state_nx  = IDLE;
          end else begin
            miss_nx  = miss_inc;
            state_nx = COAST;
          end
        end
        default: begin
          box_en_nx = 1'b0;
          miss_nx   = '0;
          state_nx  = IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_box_coord_sync.sv
//==============================================================================
// Module      : tb_box_coord_sync
// Description : Scoreboard bench for box_coord_sync. Each frame_start pushes
//               the expected committed box; a monitor pops and compares on
//               the cycle the commit becomes visible.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_box_coord_sync;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        det_valid = 1'b0;
  logic [10:0] det_x = '0, det_y = '0, det_w = '0, det_h = '0;
  logic        det_ready;
  logic [10:0] box_x, box_y, box_w, box_h;
  logic        box_en;

  typedef struct {
    string       name;
    logic [10:0] x, y, w, h;
    logic        en;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic fs_d = 1'b0;

  box_coord_sync #(
    .IMG_WIDTH(768), .IMG_HEIGHT(576), .SMOOTH_SHIFT(2), .HOLD_FRAMES(8), .MIN_SIZE(4)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .det_valid(det_valid), .det_ready(det_ready),
    .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h), .box_en(box_en)
  );

  always #5 clk = ~clk;

  // Marks the cycle in which a commit has become visible on the outputs
  always @(posedge clk) fs_d <= frame_start & reset;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: compare each visible commit against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (fs_d) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got (%0d,%0d,%0d,%0d,en=%0d) expected no commit",
                 box_x, box_y, box_w, box_h, box_en);
      end else begin
        e = q.pop_front();
        if ({box_x, box_y, box_w, box_h, box_en} !== {e.x, e.y, e.w, e.h, e.en}) begin
          errors++;
          $display("FAIL %s: got (%0d,%0d,%0d,%0d,en=%0d) expected (%0d,%0d,%0d,%0d,en=%0d)",
                   e.name, box_x, box_y, box_w, box_h, box_en, e.x, e.y, e.w, e.h, e.en);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input int x, input int y, input int w, input int h,
                          input logic en);
    exp_t e;
    e.name = nm;
    e.x = 11'(x); e.y = 11'(y); e.w = 11'(w); e.h = 11'(h); e.en = en;
    q.push_back(e);
  endtask

  task automatic drive_det(input int x, input int y, input int w, input int h);
    det_valid = 1'b1;
    det_x = 11'(x); det_y = 11'(y); det_w = 11'(w); det_h = 11'(h);
  endtask

  // One full handshake; bounded wait on det_ready
  task automatic send(input int x, input int y, input int w, input int h);
    int n;
    @(negedge clk);
    drive_det(x, y, w, h);
    n = 0;
    while (!det_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", 64'(det_ready), 64'd1);
    @(negedge clk);
    det_valid = 1'b0;
  endtask

  task automatic fs(input string nm, input int x, input int y, input int w, input int h,
                    input logic en);
    @(negedge clk);
    frame_start = 1'b1;
    push_exp(nm, x, y, w, h, en);
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Smoothing trajectory 400 -> 440 at gain 1/4
  int t2_exp[14] = '{410, 417, 422, 426, 429, 431, 433, 434, 435, 436, 437, 438, 439, 440};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_box", 64'({box_x, box_y, box_w, box_h, box_en}), 64'd0);
    chk("rst_ready", 64'(det_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(det_ready), 64'd1);
    fs("idle_no_det", 0, 0, 0, 0, 1'b0);

    // T1 first lock, no smoothing from IDLE
    send(400, 300, 100, 80);
    fs("t1_lock", 400, 300, 100, 80, 1'b1);

    // T2 smoothing converges exactly
    for (int i = 0; i < 14; i++) begin
      send(440, 300, 100, 80);
      fs($sformatf("t2_smooth_%0d", i), t2_exp[i], 300, 100, 80, 1'b1);
    end

    // T4 timeout: 7 coasting frames keep the box, the 8th drops it
    repeat (6) fs("t4_coast", 440, 300, 100, 80, 1'b1);
    @(negedge clk);
    frame_start = 1'b1;
    push_exp("t4_coast7", 440, 300, 100, 80, 1'b1);
    push_exp("t4_drop", 440, 300, 100, 80, 1'b0);
    repeat (2) @(negedge clk);
    frame_start = 1'b0;
    fs("t4_idle_hold", 440, 300, 100, 80, 1'b0);

    // T3 clamp at low edge, reloaded without smoothing after timeout
    send(10, 10, 101, 60);
    fs("t3_clamp_low_reload", 50, 30, 100, 60, 1'b1);
    // T3 reject: handshake completes but slot stays empty
    send(100, 100, 3, 20);
    chk("t3_reject_slot_empty", 64'(det_ready), 64'd1);
    fs("t3_reject_no_commit", 50, 30, 100, 60, 1'b1);
    // Clamp at high edge, smoothed from the current box
    send(760, 570, 800, 700);
    fs("t3_clamp_high", 133, 94, 266, 188, 1'b1);

    // T5 backpressure: second detection held until the commit frees the slot
    send(100, 90, 40, 20);
    @(negedge clk);
    drive_det(124, 93, 208, 147);
    chk("t5_blocked_a", 64'(det_ready), 64'd0);
    @(negedge clk);
    chk("t5_blocked_b", 64'(det_ready), 64'd0);
    frame_start = 1'b1;
    push_exp("t5_first", 124, 93, 209, 146, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    chk("t5_ready_after_commit", 64'(det_ready), 64'd1);
    @(negedge clk);
    det_valid = 1'b0;
    chk("t5_slot_refilled", 64'(det_ready), 64'd0);
    fs("t5_second", 124, 93, 208, 146, 1'b1);

    // Transfer in the frame_start cycle commits one frame later
    @(negedge clk);
    frame_start = 1'b1;
    drive_det(130, 93, 208, 146);
    chk("same_cycle_ready", 64'(det_ready), 64'd1);
    push_exp("same_cycle_no_commit", 124, 93, 208, 146, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    det_valid = 1'b0;
    fs("same_cycle_next", 125, 93, 208, 146, 1'b1);

    // T6 reset mid-TRACK with the slot full
    send(300, 200, 50, 50);
    chk("t6_slot_full", 64'(det_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_box", 64'({box_x, box_y, box_w, box_h, box_en}), 64'd0);
    chk("t6_rst_ready", 64'(det_ready), 64'd0);
    reset = 1'b1;
    chk("t6_release_cycle_ready", 64'(det_ready), 64'd0);
    @(negedge clk);
    chk("t6_ready_after_release", 64'(det_ready), 64'd1);
    fs("t6_pending_lost", 0, 0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
